generador_direcciones_imagen: RTL and testbench
===============================================

# generador_direcciones_imagen

Parametrised 2‑D read-address generator for the image memory: walks a frame of `FILAS` rows of `PALABRAS_POR_FILA` consecutive words, with row bases `PASO_FILA` words apart, starting at `DIRECCION_BASE`. It is the successor of the single row-base accumulator. It adds a column counter, a row counter, configurable stride, a start/advance/abort handshake and last-word flags. It feeds the memory read port of the filter datapath, which consumes one address per accepted `avanzar`.

## Interface
- `BITS_DIRECCION`, 11, address width; all address arithmetic is modulo 2^BITS_DIRECCION.
- `DIRECCION_BASE`, 0, address of word 0 of row 0.
- `PALABRAS_POR_FILA`, 16, words per row (≥1).
- `PASO_FILA`, 16, distance in words between consecutive row bases (≥1, may exceed `PALABRAS_POR_FILA`).
- `FILAS`, 128, rows per frame (≥1).
- `BITS_FILA`, 7, width of row index; must hold `FILAS-1`.
- `BITS_COLUMNA`, 4, width of column index; must hold `PALABRAS_POR_FILA-1`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start pulse; honoured only in REPOSO.
- `avanzar`  in  1  consumer accepted current `direccion`; honoured only when `valida`=1.
- `abortar`  in  1  synchronous abort to REPOSO.
- `direccion`  out  BITS_DIRECCION  current address (registered).
- `valida`  out  1  `direccion` is a frame address awaiting acceptance.
- `ultima_columna`  out  1  `valida` and current word is last of its row.
- `ultima_direccion`  out  1  `valida` and current word is last of the frame.
- `fila_actual`  out  BITS_FILA  row index of current word.

## Operation
- States: REPOSO, RECORRIDO.
- REPOSO: `valida`=0, `direccion`=`DIRECCION_BASE`, row/column = 0. `iniciar`=1 -> RECORRIDO; first address presented is `DIRECCION_BASE`.
- RECORRIDO: `valida`=1; `direccion` = base_fila + columna. Without `avanzar`, all outputs hold.
- `avanzar` with column < `PALABRAS_POR_FILA-1`: columna+1.
- `avanzar` on last column, row < `FILAS-1`: columna=0, base_fila += `PASO_FILA`, fila_actual+1.
- `avanzar` on last word of frame: -> REPOSO (default build), registers reloaded to reset values.
- `abortar`=1 in any state -> REPOSO with reset values; has priority over `iniciar` and `avanzar` in the same cycle.
- `iniciar` during RECORRIDO ignored; `avanzar` in REPOSO ignored.
- Address overflow past 2^BITS_DIRECCION wraps silently; no error flag.
- `ultima_columna`, `ultima_direccion` are combinational decodes of registered state; 0 whenever `valida`=0.

## Timing
- Reset values: `direccion`=`DIRECCION_BASE`, `valida`=0, `ultima_columna`=0, `ultima_direccion`=0, `fila_actual`=0, state REPOSO.
- `iniciar` sampled at edge N -> `valida`=1 and first address visible after edge N.
- `avanzar` sampled at edge N -> next address visible after edge N; one address per cycle sustained when `avanzar` held high.
- Full frame with `avanzar` held high: `FILAS*PALABRAS_POR_FILA` cycles of `valida`, then `valida`=0 the cycle after the last acceptance.
- Earliest restart: `iniciar` in the first REPOSO cycle; no dead cycles beyond that.
- `reset` assertion mid-frame: outputs to reset values immediately (asynchronous), no glitch of `valida` high afterwards.

## Configuration
- `CONTINUO_EN` defined: after acceptance of the last word of a frame the block stays in RECORRIDO and the next cycle presents `DIRECCION_BASE`, row 0 (back-to-back frames without `iniciar`); only `abortar`/`reset` return to REPOSO.
- Not defined: returns to REPOSO after the last word as described above.

## Test plan
- Params FILAS=3, PALABRAS_POR_FILA=4, PASO_FILA=16, BASE=0; `iniciar` then `avanzar` held -> addresses 0,1,2,3,16,17,18,19,32,33,34,35 on 12 consecutive cycles; `ultima_columna` on 3,19,35; `ultima_direccion` only on 35; `valida`=0 next cycle.
- Same params, `avanzar` toggled 1/0 -> each address held exactly while `avanzar`=0, sequence identical.
- BASE=2040, BITS_DIRECCION=11, PALABRAS_POR_FILA=16, FILAS=2 -> row 0 wraps 2047 -> 0..7; row 1 starts at 8 (2056 mod 2048).
- `abortar` together with `avanzar` at address 17 -> next cycle `valida`=0, `direccion`=0; later `iniciar` restarts at 0.
- `reset` low asynchronously at address 18 -> outputs at reset values before next edge; `iniciar` during RECORRIDO at address 1 -> no effect.
- With `CONTINUO_EN`: after 35 accepted, next address 0, `fila_actual`=0, `valida` stays 1.

Source files
------------

// File: rtl/generador_direcciones_imagen.sv
// generador_direcciones_imagen
// 2-D read-address generator for the image memory. It walks FILAS rows of
// PALABRAS_POR_FILA consecutive words. Row bases are PASO_FILA words apart,
// and the walk starts at DIRECCION_BASE. All address arithmetic wraps
// modulo 2^BITS_DIRECCION.
//
// Optional feature macro: CONTINUO_EN
//   defined   : after the last word of a frame is accepted, the next frame
//               starts immediately (back-to-back frames, no iniciar needed).
//   undefined : the block returns to REPOSO after the last word.
//
// The address is held in its own register and updated incrementally
// (+1 within a row, base_fila + PASO_FILA on a row change). This keeps the
// output free of the base+column adder.
module generador_direcciones_imagen #(
    parameter int BITS_DIRECCION    = 11,
    parameter int DIRECCION_BASE    = 0,
    parameter int PALABRAS_POR_FILA = 16,
    parameter int PASO_FILA         = 16,
    parameter int FILAS             = 128,
    parameter int BITS_FILA         = 7,
    parameter int BITS_COLUMNA      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      iniciar,
    input  logic                      avanzar,
    input  logic                      abortar,
    output logic [BITS_DIRECCION-1:0] direccion,
    output logic                      valida,
    output logic                      ultima_columna,
    output logic                      ultima_direccion,
    output logic [BITS_FILA-1:0]      fila_actual
);

    localparam logic [BITS_DIRECCION-1:0] BASE_INI  = BITS_DIRECCION'(DIRECCION_BASE);
    localparam logic [BITS_DIRECCION-1:0] PASO      = BITS_DIRECCION'(PASO_FILA);
    localparam logic [BITS_DIRECCION-1:0] DIR_UNO   = BITS_DIRECCION'(1);
    localparam logic [BITS_COLUMNA-1:0]   COL_MAX   = BITS_COLUMNA'(PALABRAS_POR_FILA - 1);
    localparam logic [BITS_COLUMNA-1:0]   COL_CERO  = BITS_COLUMNA'(0);
    localparam logic [BITS_COLUMNA-1:0]   COL_UNO   = BITS_COLUMNA'(1);
    localparam logic [BITS_FILA-1:0]      FILA_MAX  = BITS_FILA'(FILAS - 1);
    localparam logic [BITS_FILA-1:0]      FILA_CERO = BITS_FILA'(0);
    localparam logic [BITS_FILA-1:0]      FILA_UNO  = BITS_FILA'(1);

    typedef enum logic [0:0] {
        REPOSO    = 1'b0,
        RECORRIDO = 1'b1
    } estado_t;

    estado_t                   estado_q,    estado_d;
    logic [BITS_COLUMNA-1:0]   columna_q,   columna_d;
    logic [BITS_FILA-1:0]      fila_q,      fila_d;
    logic [BITS_DIRECCION-1:0] base_fila_q, base_fila_d;
    logic [BITS_DIRECCION-1:0] direccion_q, direccion_d;

    // State and address registers; an asynchronous reset returns everything to the frame start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= REPOSO;
            columna_q   <= COL_CERO;
            fila_q      <= FILA_CERO;
            base_fila_q <= BASE_INI;
            direccion_q <= BASE_INI;
        end else begin
            estado_q    <= estado_d;
            columna_q   <= columna_d;
            fila_q      <= fila_d;
            base_fila_q <= base_fila_d;
            direccion_q <= direccion_d;
        end
    end

    // Next-state logic: abortar wins over everything. Otherwise, step column, row or frame on each accepted address.
    always_comb begin
        estado_d    = estado_q;
        columna_d   = columna_q;
        fila_d      = fila_q;
        base_fila_d = base_fila_q;
        direccion_d = direccion_q;
        if (abortar) begin
            estado_d    = REPOSO;
            columna_d   = COL_CERO;
            fila_d      = FILA_CERO;
            base_fila_d = BASE_INI;
            direccion_d = BASE_INI;
        end else begin
            case (estado_q)
                REPOSO: begin
                    // Counters already sit at frame-start values in REPOSO.
                    if (iniciar) begin
                        estado_d = RECORRIDO;
                    end else begin
                        estado_d = REPOSO;
                    end
                end
                RECORRIDO: begin
                    if (avanzar) begin
                        if (columna_q != COL_MAX) begin
                            columna_d   = columna_q + COL_UNO;
                            direccion_d = direccion_q + DIR_UNO;
                        end else if (fila_q != FILA_MAX) begin
                            columna_d   = COL_CERO;
                            fila_d      = fila_q + FILA_UNO;
                            base_fila_d = base_fila_q + PASO;
                            direccion_d = base_fila_q + PASO;
                        end else begin
`ifdef CONTINUO_EN
                            estado_d    = RECORRIDO;
`else
                            estado_d    = REPOSO;
`endif
                            columna_d   = COL_CERO;
                            fila_d      = FILA_CERO;
                            base_fila_d = BASE_INI;
                            direccion_d = BASE_INI;
                        end
                    end else begin
                        estado_d = RECORRIDO;
                    end
                end
                default: begin
                    estado_d    = REPOSO;
                    columna_d   = COL_CERO;
                    fila_d      = FILA_CERO;
                    base_fila_d = BASE_INI;
                    direccion_d = BASE_INI;
                end
            endcase
        end
    end

    // Output decode of registered state. The last-word flags are forced low outside a frame.
    always_comb begin
        direccion        = direccion_q;
        fila_actual      = fila_q;
        valida           = (estado_q == RECORRIDO);
        ultima_columna   = (estado_q == RECORRIDO) && (columna_q == COL_MAX);
        ultima_direccion = (estado_q == RECORRIDO) && (columna_q == COL_MAX) && (fila_q == FILA_MAX);
    end

endmodule

// File: tb/tb_generador_direcciones_imagen.sv
// Testbench for generador_direcciones_imagen.
// Instance A: 3 rows x 4 words, stride 16, base 0.
// Instance B: 2 rows x 16 words, stride 16, base 2040 (exercises wrap-around).
// The reference model tracks only "active" and the linear word index k, and
// derives the address arithmetically from row = k / P and col = k % P.
module tb_generador_direcciones_imagen;

    localparam int P_A = 4, F_A = 3, PASO_A = 16, BASE_A = 0, TOT_A = 12;
    localparam int P_B = 16, F_B = 2, PASO_B = 16, BASE_B = 2040, TOT_B = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        ini_a, av_a, ab_a;
    logic [10:0] dir_a;
    logic        val_a, uc_a, ud_a;
    logic [1:0]  fila_a;
    logic        ini_b, av_b, ab_b;
    logic [10:0] dir_b;
    logic        val_b, uc_b, ud_b;
    logic [0:0]  fila_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_act_a;
    int m_k_a;

    always #5 clk = ~clk;

    generador_direcciones_imagen #(
        .BITS_DIRECCION(11), .DIRECCION_BASE(BASE_A), .PALABRAS_POR_FILA(P_A),
        .PASO_FILA(PASO_A), .FILAS(F_A), .BITS_FILA(2), .BITS_COLUMNA(2)
    ) dut_a (
        .clk(clk), .reset(reset), .iniciar(ini_a), .avanzar(av_a), .abortar(ab_a),
        .direccion(dir_a), .valida(val_a), .ultima_columna(uc_a),
        .ultima_direccion(ud_a), .fila_actual(fila_a)
    );

    generador_direcciones_imagen #(
        .BITS_DIRECCION(11), .DIRECCION_BASE(BASE_B), .PALABRAS_POR_FILA(P_B),
        .PASO_FILA(PASO_B), .FILAS(F_B), .BITS_FILA(1), .BITS_COLUMNA(4)
    ) dut_b (
        .clk(clk), .reset(reset), .iniciar(ini_b), .avanzar(av_b), .abortar(ab_b),
        .direccion(dir_b), .valida(val_b), .ultima_columna(uc_b),
        .ultima_direccion(ud_b), .fila_actual(fila_b)
    );

    function automatic logic [10:0] addr_of(int base, int p, int paso, int k);
        int v;
        v = (base + (k / p) * paso + (k % p)) % 2048;
        return 11'(v);
    endfunction

    task automatic model_step_a(bit ini, bit av, bit ab);
        if (ab) begin
            m_act_a = 1'b0; m_k_a = 0;
        end else if (!m_act_a) begin
            if (ini) begin m_act_a = 1'b1; m_k_a = 0; end
        end else if (av) begin
            m_k_a++;
            if (m_k_a == TOT_A) begin
                m_k_a = 0;
`ifndef CONTINUO_EN
                m_act_a = 1'b0;
`endif
            end
        end
    endtask

    task automatic expect_a(output logic [10:0] d, output logic v, output logic uc,
                            output logic ud, output logic [1:0] f);
        v  = m_act_a;
        d  = m_act_a ? addr_of(BASE_A, P_A, PASO_A, m_k_a) : 11'(BASE_A);
        f  = m_act_a ? 2'(m_k_a / P_A) : 2'd0;
        uc = m_act_a && ((m_k_a % P_A) == P_A - 1);
        ud = m_act_a && (m_k_a == TOT_A - 1);
    endtask

    task automatic tick_a(bit ini, bit av, bit ab);
        ini_a = ini; av_a = av; ab_a = ab;
        @(posedge clk);
        model_step_a(ini, av, ab);
        @(negedge clk);
    endtask

    task automatic tick_b(bit ini, bit av, bit ab);
        ini_b = ini; av_b = av; ab_b = ab;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        ini_a = 1'b0; av_a = 1'b0; ab_a = 1'b0;
        ini_b = 1'b0; av_b = 1'b0; ab_b = 1'b0;
        m_act_a = 1'b0; m_k_a = 0;
        #12;
        n_checks++;
        if ({dir_a, val_a, uc_a, ud_a, fila_a} !== {11'd0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_a got dir=%0d val=%b uc=%b ud=%b fila=%0d required 0/0/0/0/0",
                     dir_a, val_a, uc_a, ud_a, fila_a);
        end
        n_checks++;
        if ({dir_b, val_b, uc_b, ud_b, fila_b} !== {11'd2040, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_b got dir=%0d val=%b uc=%b ud=%b fila=%0d required 2040/0/0/0/0",
                     dir_b, val_b, uc_b, ud_b, fila_b);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_frame;
        logic [10:0] tbl [12] = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd16, 11'd17,
                                  11'd18, 11'd19, 11'd32, 11'd33, 11'd34, 11'd35};
        logic        e_uc, e_ud;
        logic [1:0]  e_f;
        tick_a(1'b0, 1'b0, 1'b1);
        tick_a(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            e_uc = ((i % 4) == 3);
            e_ud = (i == 11);
            e_f  = 2'(i / 4);
            n_checks++;
            if ({dir_a, val_a, uc_a, ud_a, fila_a} !== {tbl[i], 1'b1, e_uc, e_ud, e_f}) begin
                n_fail++;
                $display("FAIL frame i=%0d got dir=%0d val=%b uc=%b ud=%b fila=%0d required %0d/1/%b/%b/%0d",
                         i, dir_a, val_a, uc_a, ud_a, fila_a, tbl[i], e_uc, e_ud, e_f);
            end
            tick_a(1'b0, 1'b1, 1'b0);
        end
`ifdef CONTINUO_EN
        n_checks++;
        if ({dir_a, val_a, fila_a} !== {11'd0, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL frame_continuo got dir=%0d val=%b fila=%0d required 0/1/0", dir_a, val_a, fila_a);
        end
`else
        n_checks++;
        if ({dir_a, val_a, uc_a, ud_a, fila_a} !== {11'd0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL frame_end got dir=%0d val=%b uc=%b ud=%b fila=%0d required 0/0/0/0/0",
                     dir_a, val_a, uc_a, ud_a, fila_a);
        end
`endif
        tick_a(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_toggle;
        logic [10:0] e_d;
        tick_a(1'b0, 1'b0, 1'b1);
        tick_a(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            e_d = addr_of(BASE_A, P_A, PASO_A, i);
            tick_a(1'b0, 1'b0, 1'b0);
            n_checks++;
            if ({dir_a, val_a} !== {e_d, 1'b1}) begin
                n_fail++;
                $display("FAIL toggle_hold i=%0d got dir=%0d val=%b required %0d/1", i, dir_a, val_a, e_d);
            end
            tick_a(1'b0, 1'b1, 1'b0);
        end
        tick_a(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap;
        logic [10:0] e_d;
        logic        e_uc, e_ud;
        logic [0:0]  e_f;
        tick_b(1'b0, 1'b0, 1'b1);
        tick_b(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < TOT_B; k++) begin
            e_d  = addr_of(BASE_B, P_B, PASO_B, k);
            e_uc = ((k % P_B) == P_B - 1);
            e_ud = (k == TOT_B - 1);
            e_f  = 1'(k / P_B);
            n_checks++;
            if ({dir_b, val_b, uc_b, ud_b, fila_b} !== {e_d, 1'b1, e_uc, e_ud, e_f}) begin
                n_fail++;
                $display("FAIL wrap k=%0d got dir=%0d val=%b uc=%b ud=%b fila=%0d required %0d/1/%b/%b/%0d",
                         k, dir_b, val_b, uc_b, ud_b, fila_b, e_d, e_uc, e_ud, e_f);
            end
            if (k == 8) begin
                n_checks++;
                if (dir_b !== 11'd0) begin
                    n_fail++;
                    $display("FAIL wrap_row0 got dir=%0d required 0", dir_b);
                end
            end
            if (k == 16) begin
                n_checks++;
                if (dir_b !== 11'd8) begin
                    n_fail++;
                    $display("FAIL wrap_row1 got dir=%0d required 8", dir_b);
                end
            end
            tick_b(1'b0, 1'b1, 1'b0);
        end
`ifdef CONTINUO_EN
        n_checks++;
        if ({dir_b, val_b} !== {11'd2040, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_continuo got dir=%0d val=%b required 2040/1", dir_b, val_b);
        end
`else
        n_checks++;
        if ({dir_b, val_b} !== {11'd2040, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_end got dir=%0d val=%b required 2040/0", dir_b, val_b);
        end
`endif
        tick_b(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_abort;
        tick_a(1'b0, 1'b0, 1'b1);
        tick_a(1'b1, 1'b0, 1'b0);
        repeat (5) tick_a(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({dir_a, val_a} !== {11'd17, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_pre got dir=%0d val=%b required 17/1", dir_a, val_a);
        end
        tick_a(1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({dir_a, val_a, fila_a} !== {11'd0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL abort_post got dir=%0d val=%b fila=%0d required 0/0/0", dir_a, val_a, fila_a);
        end
        tick_a(1'b0, 1'b0, 1'b0);
        tick_a(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({dir_a, val_a} !== {11'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_restart got dir=%0d val=%b required 0/1", dir_a, val_a);
        end
        tick_a(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_ignored;
        tick_a(1'b0, 1'b0, 1'b1);
        tick_a(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({dir_a, val_a} !== {11'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL avanzar_idle got dir=%0d val=%b required 0/0", dir_a, val_a);
        end
        tick_a(1'b1, 1'b0, 1'b0);
        tick_a(1'b0, 1'b1, 1'b0);
        tick_a(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({dir_a, val_a} !== {11'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL iniciar_busy got dir=%0d val=%b required 1/1", dir_a, val_a);
        end
        tick_a(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (dir_a !== 11'd2) begin
            n_fail++;
            $display("FAIL iniciar_busy_adv got dir=%0d required 2", dir_a);
        end
        tick_a(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset;
        tick_a(1'b0, 1'b0, 1'b1);
        tick_a(1'b1, 1'b0, 1'b0);
        repeat (6) tick_a(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({dir_a, val_a, fila_a} !== {11'd18, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL areset_pre got dir=%0d val=%b fila=%0d required 18/1/1", dir_a, val_a, fila_a);
        end
        reset = 1'b0;
        #1;
        m_act_a = 1'b0; m_k_a = 0;
        n_checks++;
        if ({dir_a, val_a, uc_a, ud_a, fila_a} !== {11'd0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL areset_now got dir=%0d val=%b uc=%b ud=%b fila=%0d required 0/0/0/0/0",
                     dir_a, val_a, uc_a, ud_a, fila_a);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (val_a !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_hold got val=%b required 0", val_a);
        end
        @(negedge clk);
        reset = 1'b1;
        tick_a(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({dir_a, val_a} !== {11'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL areset_release got dir=%0d val=%b required 0/0", dir_a, val_a);
        end
    endtask

    task automatic test_random;
        logic [10:0] e_d;
        logic        e_v, e_uc, e_ud;
        logic [1:0]  e_f;
        bit          ini, av, ab;
        tick_a(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 600; c++) begin
            ini = ($urandom_range(0, 7) == 0);
            av  = ($urandom_range(0, 3) != 0);
            ab  = ($urandom_range(0, 59) == 0);
            tick_a(ini, av, ab);
            expect_a(e_d, e_v, e_uc, e_ud, e_f);
            n_checks++;
            if ({dir_a, val_a, uc_a, ud_a, fila_a} !== {e_d, e_v, e_uc, e_ud, e_f}) begin
                n_fail++;
                $display("FAIL random c=%0d got dir=%0d val=%b uc=%b ud=%b fila=%0d required %0d/%b/%b/%b/%0d",
                         c, dir_a, val_a, uc_a, ud_a, fila_a, e_d, e_v, e_uc, e_ud, e_f);
            end
        end
        tick_a(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_toggle();
        test_wrap();
        test_abort();
        test_ignored();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
